alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that shares the single integer ALU between two requesters, e.g. the integer issue port and the branch-resolution port. Each requester presents a complete ALU operation (operands, ALU control, branch control) with a valid/ready handshake. The arbiter drives the granted operation into the combinational ALU and captures `ALUResult`/`Zero` into a per-requester response register. Results return one cycle later through a valid/ready response handshake.

## Interface
- `XLEN`, 32, operand/result width; must match the ALU (32).
- `CTRL_W`, 7, ALU control width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r0_valid` / `r1_valid`  in  1  request valid.
- `r0_ready` / `r1_ready`  out  1  request accepted this cycle (grant).
- `r0_src_a`, `r0_src_b` / `r1_src_a`, `r1_src_b`  in  XLEN  operands.
- `r0_alu_ctrl` / `r1_alu_ctrl`  in  CTRL_W  ALU operation code.
- `r0_br_ctrl` / `r1_br_ctrl`  in  2  compare select: 01 eq, 11 ltu, 10 lt, 00 none.
- `alu_src_a`, `alu_src_b`  out  XLEN  to ALU `SrcA`/`SrcB`.
- `alu_control`  out  CTRL_W  to ALU `ALUControl`.
- `alu_branch_control`  out  2  to ALU `BranchControl`.
- `alu_result`  in  XLEN  from ALU `ALUResult`.
- `alu_zero`  in  1  from ALU `Zero`.
- `r0_resp_valid` / `r1_resp_valid`  out  1  response register holds a result.
- `r0_resp_ready` / `r1_resp_ready`  in  1  consumer takes the response this cycle.
- `r0_resp_result` / `r1_resp_result`  out  XLEN  captured `alu_result`.
- `r0_resp_zero` / `r1_resp_zero`  out  1  captured `alu_zero`.
- `prio`  out  1  round-robin pointer: 0 means r0 preferred, 1 means r1 preferred.

## Operation
- Slot free: `free_i = !ri_resp_valid || ri_resp_ready`. Draining and refilling in the same cycle is allowed.
- Eligible: `elig_i = ri_valid && free_i && !rst`.
- Grant (combinational, at most one per cycle):
  - Both eligible: the requester selected by `prio` is granted.
  - One eligible: that requester is granted.
  - None eligible: no grant.
- `ri_ready = grant_i`. A request transfers when `ri_valid && ri_ready`.
- ALU drive: the granted requester's `src_a`, `src_b`, `alu_ctrl` and `br_ctrl` are muxed to the `alu_*` outputs. With no grant, all `alu_*` outputs are 0 (ADD, no compare).
- Pointer update: on any grant, `prio <= ~granted_index`. With no grant, `prio` holds.
- Response register `i` at each edge:
  - If `grant_i`: `resp_valid <= 1`, `resp_result <= alu_result`, `resp_zero <= alu_zero`.
  - Else if `ri_resp_ready`: `resp_valid <= 0`, and data holds.
  - Otherwise the register holds.
- Response data is stable while `resp_valid && !resp_ready`.
- No reordering: each requester has at most one outstanding response.

## Timing
- Reset values: `prio = 0`; `r0/r1_resp_valid = 0`, `resp_result = 0`, `resp_zero = 0`.
- While `rst` is high, `ri_ready = 0` and `alu_*` outputs are 0.
- Reset mid-operation: a pending response is discarded. A request valid in the reset cycle is not accepted.
- Latency: request accepted at edge N, response valid from cycle N+1.
- Throughput: one ALU operation per cycle in total. With both requesters saturated and consumers always ready, grants alternate every cycle.
- `ri_ready` depends combinationally on `ri_valid`, `ri_resp_valid`, `ri_resp_ready`, `prio` and `rst`. `ri_ready` must not depend on `alu_result`.
- Starvation bound: a continuously eligible requester is granted within 2 cycles.

## Test plan
- **Single request.** Reset, then `r0_valid=1`, `src_a=5`, `src_b=3`, `alu_ctrl=0` (ADD) for one cycle.
  - Required: `r0_ready=1` that cycle.
  - Next cycle: `r0_resp_valid=1`, `r0_resp_result=8`.
  - `prio=1` afterwards.
- **Contention.** Both requesters hold valid for 4 cycles; r0 does SUB 10-4, r1 does XOR 0xF0^0x0F; resp_ready is tied to 1.
  - Required grants: r0, r1, r0, r1.
  - Required results: 6 on r0 and 0xFF on r1.
- **Backpressure.** r0 holds a response with `r0_resp_ready=0`; both requesters present requests.
  - Required: `r0_ready=0` and r1 is granted every cycle it is valid.
  - Then assert `r0_resp_ready=1`: r0 is granted that same cycle (if `prio=0` or r1 is idle), and the new result replaces the old one next cycle.
- **Branch compare.** r1 requests `br_ctrl=10`, `src_a=0xFFFFFFFF`, `src_b=1`. Required: `r1_resp_zero=1`.
  - Repeat with `br_ctrl=11`. Required: `r1_resp_zero=0`.
- **Reset mid-operation.** With `r0_resp_valid=1` pending and both requesters valid, assert `rst` for one cycle.
  - Required: both `ready=0` that cycle.
  - Next cycle: both `resp_valid=0` and `prio=0`.
  - Following cycle: r0 is granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational integer ALU between two
// requesters with round-robin priority. Each requester's result is
// captured into its own response register and returned one cycle after
// the request is accepted.
module alu_share_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 7
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [XLEN-1:0]   r0_src_a,
  input  logic [XLEN-1:0]   r0_src_b,
  input  logic [CTRL_W-1:0] r0_alu_ctrl,
  input  logic [1:0]        r0_br_ctrl,

  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [XLEN-1:0]   r1_src_a,
  input  logic [XLEN-1:0]   r1_src_b,
  input  logic [CTRL_W-1:0] r1_alu_ctrl,
  input  logic [1:0]        r1_br_ctrl,

  output logic [XLEN-1:0]   alu_src_a,
  output logic [XLEN-1:0]   alu_src_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic [1:0]        alu_branch_control,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,

  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  output logic [XLEN-1:0]   r0_resp_result,
  output logic              r0_resp_zero,

  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [XLEN-1:0]   r1_resp_result,
  output logic              r1_resp_zero,

  output logic              prio
);

  logic free0, free1;
  logic elig0, elig1;
  logic grant0, grant1;

  // Eligibility and grant. A slot is free if empty or being drained this
  // cycle, so a held response blocks only its own requester. The grant
  // never looks at alu_result, which keeps the ALU path loop-free.
  always_comb begin
    free0  = !r0_resp_valid || r0_resp_ready;
    free1  = !r1_resp_valid || r1_resp_ready;
    elig0  = r0_valid && free0 && !rst;
    elig1  = r1_valid && free1 && !rst;
    grant0 = elig0 && (!elig1 || !prio);
    grant1 = elig1 && (!elig0 ||  prio);
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Steer the granted operation into the ALU; idle drives zeros (ADD, no compare).
  always_comb begin
    alu_src_a          = '0;
    alu_src_b          = '0;
    alu_control        = '0;
    alu_branch_control = 2'b00;
    if (grant0) begin
      alu_src_a          = r0_src_a;
      alu_src_b          = r0_src_b;
      alu_control        = r0_alu_ctrl;
      alu_branch_control = r0_br_ctrl;
    end else if (grant1) begin
      alu_src_a          = r1_src_a;
      alu_src_b          = r1_src_b;
      alu_control        = r1_alu_ctrl;
      alu_branch_control = r1_br_ctrl;
    end
  end

  // Round-robin pointer: after a grant, prefer the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end

  // Requester 0 response register: refill on grant, else clear on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_resp_valid  <= 1'b0;
      r0_resp_result <= '0;
      r0_resp_zero   <= 1'b0;
    end else if (grant0) begin
      r0_resp_valid  <= 1'b1;
      r0_resp_result <= alu_result;
      r0_resp_zero   <= alu_zero;
    end else if (r0_resp_ready) begin
      r0_resp_valid  <= 1'b0;
    end
  end

  // Requester 1 response register: refill on grant, else clear on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_resp_valid  <= 1'b0;
      r1_resp_result <= '0;
      r1_resp_zero   <= 1'b0;
    end else if (grant1) begin
      r1_resp_valid  <= 1'b1;
      r1_resp_result <= alu_result;
      r1_resp_zero   <= alu_zero;
    end else if (r1_resp_ready) begin
      r1_resp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: self-checking bench with a behavioural ALU and a
// per-requester response scoreboard.
module tb_alu_share_arbiter;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 7;

  localparam logic [CTRL_W-1:0] OP_ADD = 7'd0;
  localparam logic [CTRL_W-1:0] OP_SUB = 7'd1;
  localparam logic [CTRL_W-1:0] OP_XOR = 7'd4;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_valid, r1_valid;
  logic              r0_ready, r1_ready;
  logic [XLEN-1:0]   r0_src_a, r0_src_b, r1_src_a, r1_src_b;
  logic [CTRL_W-1:0] r0_alu_ctrl, r1_alu_ctrl;
  logic [1:0]        r0_br_ctrl, r1_br_ctrl;
  logic [XLEN-1:0]   alu_src_a, alu_src_b;
  logic [CTRL_W-1:0] alu_control;
  logic [1:0]        alu_branch_control;
  logic [XLEN-1:0]   alu_result;
  logic              alu_zero;
  logic              r0_resp_valid, r1_resp_valid;
  logic              r0_resp_ready, r1_resp_ready;
  logic [XLEN-1:0]   r0_resp_result, r1_resp_result;
  logic              r0_resp_zero, r1_resp_zero;
  logic              prio;

  int total = 0;
  int bad   = 0;

  logic [XLEN:0] q0[$];
  logic [XLEN:0] q1[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready),
    .r0_src_a(r0_src_a), .r0_src_b(r0_src_b),
    .r0_alu_ctrl(r0_alu_ctrl), .r0_br_ctrl(r0_br_ctrl),
    .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r1_src_a(r1_src_a), .r1_src_b(r1_src_b),
    .r1_alu_ctrl(r1_alu_ctrl), .r1_br_ctrl(r1_br_ctrl),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .alu_branch_control(alu_branch_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r0_resp_result(r0_resp_result), .r0_resp_zero(r0_resp_zero),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .r1_resp_result(r1_resp_result), .r1_resp_zero(r1_resp_zero),
    .prio(prio)
  );

  // Behavioural ALU: returns {zero, result}. With a compare selected, zero
  // carries the compare outcome; otherwise it flags a zero result.
  function automatic logic [XLEN:0] alu_model(input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b,
                                              input logic [CTRL_W-1:0] op,
                                              input logic [1:0] br);
    logic [XLEN-1:0] res;
    logic            z;
    case (op)
      OP_SUB:  res = a - b;
      OP_XOR:  res = a ^ b;
      default: res = a + b;
    endcase
    case (br)
      2'b01:   z = (a == b);
      2'b11:   z = (a < b);
      2'b10:   z = ($signed(a) < $signed(b));
      default: z = (res == '0);
    endcase
    return {z, res};
  endfunction

  assign {alu_zero, alu_result} = alu_model(alu_src_a, alu_src_b, alu_control, alu_branch_control);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop/compare on response handshake first, then push the
  // expected result of any request accepted this cycle. Reset flushes.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (r0_resp_valid && r0_resp_ready) begin
        if (q0.size() == 0) chk("r0_unexpected_resp", 64'(r0_resp_valid), 64'd0);
        else chk("r0_sb", 64'({r0_resp_zero, r0_resp_result}), 64'(q0.pop_front()));
      end
      if (r1_resp_valid && r1_resp_ready) begin
        if (q1.size() == 0) chk("r1_unexpected_resp", 64'(r1_resp_valid), 64'd0);
        else chk("r1_sb", 64'({r1_resp_zero, r1_resp_result}), 64'(q1.pop_front()));
      end
      if (r0_valid && r0_ready) q0.push_back(alu_model(r0_src_a, r0_src_b, r0_alu_ctrl, r0_br_ctrl));
      if (r1_valid && r1_ready) q1.push_back(alu_model(r1_src_a, r1_src_b, r1_alu_ctrl, r1_br_ctrl));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_valid = 0; r1_valid = 0;
    r0_src_a = 0; r0_src_b = 0; r0_alu_ctrl = OP_ADD; r0_br_ctrl = 2'b00;
    r1_src_a = 0; r1_src_b = 0; r1_alu_ctrl = OP_ADD; r1_br_ctrl = 2'b00;
  endtask

  task automatic do_reset();
    idle();
    r0_resp_ready = 1; r1_resp_ready = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_prio", 64'(prio), 64'd0);
    chk("rst_r0_valid", 64'(r0_resp_valid), 64'd0);
    chk("rst_r1_valid", 64'(r1_resp_valid), 64'd0);
    chk("rst_r0_result", 64'(r0_resp_result), 64'd0);
    chk("rst_r1_zero", 64'(r1_resp_zero), 64'd0);
    chk("idle_alu_a", 64'(alu_src_a), 64'd0);
    tick();

    // Single request: 5 + 3
    r0_valid = 1; r0_src_a = 5; r0_src_b = 3; r0_alu_ctrl = OP_ADD;
    @(negedge clk);
    chk("single_r0_ready", 64'(r0_ready), 64'd1);
    chk("single_alu_a", 64'(alu_src_a), 64'd5);
    tick();
    idle();
    @(negedge clk);
    chk("single_resp_valid", 64'(r0_resp_valid), 64'd1);
    chk("single_resp_result", 64'(r0_resp_result), 64'd8);
    chk("single_prio", 64'(prio), 64'd1);
    tick();

    // Contention: r0 SUB 10-4, r1 XOR 0xF0^0x0F, expect r0,r1,r0,r1
    do_reset();
    r0_valid = 1; r0_src_a = 10; r0_src_b = 4; r0_alu_ctrl = OP_SUB;
    r1_valid = 1; r1_src_a = 32'hF0; r1_src_b = 32'h0F; r1_alu_ctrl = OP_XOR;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("cont_r0_grant%0d", k), 64'(r0_ready), 64'((k % 2) == 0));
      chk($sformatf("cont_r1_grant%0d", k), 64'(r1_ready), 64'((k % 2) == 1));
      tick();
    end
    idle();
    @(negedge clk);
    chk("cont_r0_result", 64'(r0_resp_result), 64'd6);
    chk("cont_r1_result", 64'(r1_resp_result), 64'hFF);
    chk("cont_r1_valid", 64'(r1_resp_valid), 64'd1);
    tick();

    // Backpressure on r0
    do_reset();
    r0_resp_ready = 0;
    r0_valid = 1; r0_src_a = 1; r0_src_b = 2;
    @(negedge clk);
    chk("bp_first_grant", 64'(r0_ready), 64'd1);
    tick();
    r0_src_a = 10; r0_src_b = 20;
    r1_valid = 1;
    for (int k = 0; k < 3; k++) begin
      r1_src_a = 32'(100 + k); r1_src_b = 32'(k);
      @(negedge clk);
      chk($sformatf("bp_r0_blocked%0d", k), 64'(r0_ready), 64'd0);
      chk($sformatf("bp_r1_grant%0d", k), 64'(r1_ready), 64'd1);
      chk($sformatf("bp_r0_hold%0d", k), 64'(r0_resp_result), 64'd3);
      tick();
    end
    r0_resp_ready = 1;
    @(negedge clk);
    chk("bp_release_prio", 64'(prio), 64'd0);
    chk("bp_release_r0", 64'(r0_ready), 64'd1);
    chk("bp_release_r1", 64'(r1_ready), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("bp_new_valid", 64'(r0_resp_valid), 64'd1);
    chk("bp_new_result", 64'(r0_resp_result), 64'd30);
    tick();

    // Branch compare on r1
    r1_valid = 1; r1_src_a = 32'hFFFF_FFFF; r1_src_b = 1; r1_br_ctrl = 2'b10;
    tick();
    r1_br_ctrl = 2'b11;
    @(negedge clk);
    chk("br_lt_zero", 64'(r1_resp_zero), 64'd1);
    tick();
    idle();
    @(negedge clk);
    chk("br_ltu_zero", 64'(r1_resp_zero), 64'd0);
    tick();

    // Reset mid-operation
    r0_resp_ready = 0;
    r0_valid = 1; r0_src_a = 7; r0_src_b = 7;
    tick();
    r0_src_a = 9;
    r1_valid = 1; r1_src_a = 11;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_r0_ready", 64'(r0_ready), 64'd0);
    chk("mid_rst_r1_ready", 64'(r1_ready), 64'd0);
    chk("mid_rst_alu_a", 64'(alu_src_a), 64'd0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_r0_valid", 64'(r0_resp_valid), 64'd0);
    chk("post_rst_r1_valid", 64'(r1_resp_valid), 64'd0);
    chk("post_rst_prio", 64'(prio), 64'd0);
    chk("post_rst_r0_first", 64'(r0_ready), 64'd1);
    chk("post_rst_r1_wait", 64'(r1_ready), 64'd0);
    tick();
    idle();
    r0_resp_ready = 1;

    // Drain everything and confirm nothing is left outstanding
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    chk("drain_r0_valid", 64'(r0_resp_valid), 64'd0);
    chk("drain_r1_valid", 64'(r1_resp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
